blink_arbiter: RTL

Shares the single board `blinker` LED output among several requesters, such as the switch-sequence FSM, fault monitors and a host-control path. Each requester asks for a blink burst with a given half-period and pulse count. The arbiter grants requesters round-robin, times the burst, and returns a one-cycle `done`. It sits between the board-level control FSMs and the LED pin and replaces ad-hoc free-running blink logic.

---
 rtl/blink_pkg.sv | 16 +
 rtl/rr_picker.sv | 39 +++
 rtl/blink_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared types and defaults for the LED blink arbiter and its helpers.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        DONE
    } state_e;

    localparam int NUM_REQ_DEF          = 3;
    localparam int PERIOD_W_DEF         = 32;
    localparam int COUNT_W_DEF          = 8;
    localparam int BLINK_PERIOD_DEFAULT = 25_000_000;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after last_owner_i, with wrap.
module rr_picker
    import blink_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_owner_i,
    output logic [NUM_REQ-1:0] win_oh_o,
    output logic [IDX_W-1:0]   win_idx_o,
    output logic               any_o
);

    int               j;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        idx       = '0;
        // Offset 1..NUM_REQ so the previous owner is considered last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = int'(last_owner_i) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = IDX_W'(j);
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                win_idx_o     = idx;
                win_oh_o[idx] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/blink_arbiter.sv
// Round-robin owner of the board LED: times ON/OFF bursts for the granted requester.
module blink_arbiter
    import blink_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int COUNT_W  = COUNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*PERIOD_W-1:0] req_period,
    input  logic [NUM_REQ*COUNT_W-1:0]  req_count,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic                        busy,
    output logic                        blinker
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e               state_q;
    logic [NUM_REQ-1:0]   grant_q, done_q;
    logic                 blinker_q;
    logic [IDX_W-1:0]     owner_q, last_q;
    logic [PERIOD_W-1:0]  period_q, cnt_q;
    logic [COUNT_W-1:0]   pulses_q;

    logic [NUM_REQ-1:0]   win_oh;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;
    logic [PERIOD_W-1:0]  per_a [NUM_REQ];
    logic [COUNT_W-1:0]   cnt_a [NUM_REQ];
    logic [PERIOD_W-1:0]  period_d;
    logic [COUNT_W-1:0]   pulses_d;
    logic                 owner_req;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign per_a[i] = req_period[i*PERIOD_W +: PERIOD_W];
        assign cnt_a[i] = req_count[i*COUNT_W +: COUNT_W];
    end

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i        (req),
        .last_owner_i (last_q),
        .win_oh_o     (win_oh),
        .win_idx_o    (win_idx),
        .any_o        (win_any)
    );

    // A zero half-period would never expire cleanly; run it as one clock.
    assign period_d  = (per_a[win_idx] == '0) ? PERIOD_W'(1) : per_a[win_idx];
    assign pulses_d  = cnt_a[win_idx];
    assign owner_req = req[owner_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            blinker_q <= 1'b0;
            owner_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            period_q  <= '0;
            cnt_q     <= '0;
            pulses_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (win_any) begin
                    grant_q  <= win_oh;
                    owner_q  <= win_idx;
                    period_q <= period_d;
                    if (pulses_d != '0) begin
                        blinker_q <= 1'b1;
                        cnt_q     <= period_d - PERIOD_W'(1);
                        pulses_q  <= pulses_d;
                        state_q   <= ON;
                    end else begin
                        done_q  <= win_oh;
                        state_q <= DONE;
                    end
                end
                ON: if (!owner_req) begin
                    blinker_q <= 1'b0;
                    grant_q   <= '0;
                    last_q    <= owner_q;
                    state_q   <= IDLE;
                end else if (cnt_q != '0) begin
                    cnt_q <= cnt_q - PERIOD_W'(1);
                end else if (pulses_q == COUNT_W'(1)) begin
                    blinker_q <= 1'b0;
                    done_q    <= grant_q;
                    state_q   <= DONE;
                end else begin
                    blinker_q <= 1'b0;
                    pulses_q  <= pulses_q - COUNT_W'(1);
                    cnt_q     <= period_q - PERIOD_W'(1);
                    state_q   <= OFF;
                end
                OFF: if (!owner_req) begin
                    blinker_q <= 1'b0;
                    grant_q   <= '0;
                    last_q    <= owner_q;
                    state_q   <= IDLE;
                end else if (cnt_q != '0) begin
                    cnt_q <= cnt_q - PERIOD_W'(1);
                end else begin
                    blinker_q <= 1'b1;
                    cnt_q     <= period_q - PERIOD_W'(1);
                    state_q   <= ON;
                end
                DONE: begin
                    done_q  <= '0;
                    grant_q <= '0;
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);
    assign blinker = blinker_q;

endmodule
